// File: rtl/nyan_pkg.sv
// Shared sprite geometry and the fixed 16-entry {R,G,B} 3:3:3 palette.
package nyan_pkg;

  localparam int SPRITE_W      = 32;
  localparam int SPRITE_H      = 32;
  localparam int SPRITE_ADDR_W = 10;
  localparam int SPRITE_DATA_W = 4;

  // Packed so index 0 is the rightmost entry; index 0 is black, the usual key colour.
  localparam logic [15:0][8:0] PALETTE = {
    9'h1D2, 9'h0C7, 9'h1B6, 9'h0A4, 9'h092, 9'h124, 9'h1E6, 9'h1C7,
    9'h007, 9'h03F, 9'h038, 9'h1F8, 9'h1E0, 9'h1C0, 9'h1FF, 9'h000
  };

endpackage

// File: rtl/nyan_palette.sv
// Registered index-to-RGB lookup, last stage of the sprite pipeline.
// Defining NYAN_TRANSPARENCY_EN renders index 0 inside the box as the background.
module nyan_palette
  import nyan_pkg::*;
#(
  parameter logic [8:0] BG_COLOR = 9'h008
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_active,
  input  logic                     i_in_box,
  input  logic [SPRITE_DATA_W-1:0] i_index,
  output logic [2:0]               o_red,
  output logic [2:0]               o_grn,
  output logic [2:0]               o_blu
);

  logic [8:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = '0;
    if (i_active) begin
      if (i_in_box) begin
        rgb_d = PALETTE[i_index];
`ifdef NYAN_TRANSPARENCY_EN
        if (i_index == '0) rgb_d = BG_COLOR;
`else
`endif
      end else begin
        rgb_d = BG_COLOR;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rgb_q <= '0;
    else          rgb_q <= rgb_d;
  end

  assign o_red = rgb_q[8:6];
  assign o_grn = rgb_q[5:3];
  assign o_blu = rgb_q[2:0];

endmodule

// File: rtl/nyan_sprite_reader.sv
// Scrolls a 32x32 palette sprite across the raster through a 3-cycle pixel pipeline.
// Optional NYAN_TRANSPARENCY_EN (handled in nyan_palette) makes index 0 transparent.
module nyan_sprite_reader
  import nyan_pkg::*;
#(
  parameter int         ACTIVE_COLS = 640,
  parameter int         ACTIVE_ROWS = 480,
  parameter int         SCALE_LOG2  = 1,
  parameter int         FRAME_DIV   = 2,
  parameter logic [8:0] BG_COLOR    = 9'h008
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_hsync,
  input  logic                     i_vsync,
  input  logic [9:0]               i_col_count,
  input  logic [9:0]               i_row_count,
  input  logic [9:0]               i_sprite_y,
  output logic [SPRITE_ADDR_W-1:0] o_mem_addr,
  input  logic [SPRITE_DATA_W-1:0] i_mem_data,
  output logic                     o_hsync,
  output logic                     o_vsync,
  output logic [2:0]               o_red,
  output logic [2:0]               o_grn,
  output logic [2:0]               o_blu,
  output logic                     o_frame_tick
);

  localparam int               BOX_W    = SPRITE_W << SCALE_LOG2;
  localparam int               BOX_H    = SPRITE_H << SCALE_LOG2;
  localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [9:0]       COL_LAST = 10'(ACTIVE_COLS - 1);

  logic [9:0]               sprite_x_q, sprite_x_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic                     tick_q, tick_d;
  logic [SPRITE_ADDR_W-1:0] addr_q, addr_d;
  logic                     box1_q, act1_q, box2_q, act2_q;
  logic [SPRITE_DATA_W-1:0] idx2_q;
  logic [2:0]               hs_q, vs_q;

  logic [10:0] dx, dy;
  logic        active, in_box, frame_start;

  // 11-bit differences: a count left of / above the sprite wraps high and fails the box test.
  always_comb begin
    dx          = {1'b0, i_col_count} - {1'b0, sprite_x_q};
    dy          = {1'b0, i_row_count} - {1'b0, i_sprite_y};
    active      = ({1'b0, i_col_count} < 11'(ACTIVE_COLS)) &&
                  ({1'b0, i_row_count} < 11'(ACTIVE_ROWS));
    in_box      = active && (dx < 11'(BOX_W)) && (dy < 11'(BOX_H));
    addr_d      = in_box ? {dy[SCALE_LOG2 +: 5], dx[SCALE_LOG2 +: 5]} : addr_q;
    frame_start = (i_col_count == '0) && (i_row_count == '0);
  end

  always_comb begin
    div_d      = div_q;
    sprite_x_d = sprite_x_q;
    tick_d     = 1'b0;
    if (frame_start) begin
      if (div_q == DIV_LAST) begin
        div_d      = '0;
        sprite_x_d = (sprite_x_q == COL_LAST) ? '0 : sprite_x_q + 10'd1;
        tick_d     = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sprite_x_q <= '0;
      div_q      <= '0;
      tick_q     <= 1'b0;
      addr_q     <= '0;
      box1_q     <= 1'b0;
      act1_q     <= 1'b0;
      box2_q     <= 1'b0;
      act2_q     <= 1'b0;
      idx2_q     <= '0;
      hs_q       <= '0;
      vs_q       <= '0;
    end else begin
      sprite_x_q <= sprite_x_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      addr_q     <= addr_d;
      box1_q     <= in_box;
      act1_q     <= active;
      box2_q     <= box1_q;
      act2_q     <= act1_q;
      idx2_q     <= i_mem_data;
      hs_q       <= {hs_q[1:0], i_hsync};
      vs_q       <= {vs_q[1:0], i_vsync};
    end
  end

  nyan_palette #(
    .BG_COLOR(BG_COLOR)
  ) u_palette (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_active(act2_q),
    .i_in_box(box2_q),
    .i_index (idx2_q),
    .o_red   (o_red),
    .o_grn   (o_grn),
    .o_blu   (o_blu)
  );

  assign o_mem_addr   = addr_q;
  assign o_hsync      = hs_q[2];
  assign o_vsync      = vs_q[2];
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_nyan_sprite_reader.sv
// Self-checking bench for nyan_sprite_reader: directed probes plus randomized raster traffic.
module tb_nyan_sprite_reader;

  localparam int         COLS  = 640;
  localparam int         ROWS  = 480;
  localparam int         SCALE = 2;
  localparam int         BOX   = 32 * SCALE;
  localparam int         FDIV  = 2;
  localparam logic [8:0] BG    = 9'h008;
  localparam int K_BLACK = 0, K_BG = 1, K_SPR = 2;

  logic       clk, rst_n, hs_i, vs_i, hs_o, vs_o, frame_tick;
  logic [9:0] col_c, row_c, sy_c, mem_addr;
  logic [3:0] mem_data;
  logic [2:0] red, grn, blu;

  logic [3:0] ram [1024];
  logic [8:0] pal [16] = '{9'h000, 9'h1FF, 9'h1C0, 9'h1E0, 9'h1F8, 9'h038, 9'h03F, 9'h007,
                           9'h1C7, 9'h1E6, 9'h124, 9'h092, 9'h0A4, 9'h1B6, 9'h0C7, 9'h1D2};

  assign mem_data = ram[mem_addr];

  nyan_sprite_reader #(
    .ACTIVE_COLS(COLS), .ACTIVE_ROWS(ROWS), .SCALE_LOG2(1), .FRAME_DIV(FDIV), .BG_COLOR(BG)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hs_i), .i_vsync(vs_i),
    .i_col_count(col_c), .i_row_count(row_c), .i_sprite_y(sy_c),
    .o_mem_addr(mem_addr), .i_mem_data(mem_data), .o_hsync(hs_o), .o_vsync(vs_o),
    .o_red(red), .o_grn(grn), .o_blu(blu), .o_frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [8:0] rgb; logic hs; logic vs; } exp_t;
  typedef struct { int col; int row; int sy; int addr; int kind; } vec_t;

  exp_t       exp_q[$];
  int         m_sx, m_div, nvec, nerr, tick_seen;
  logic [9:0] m_addr, last_addr;
  logic [8:0] last_rgb;

  function automatic void check(input string name, input int act, input int want);
    nvec++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endfunction

  function automatic logic [8:0] sprite_rgb(input logic [3:0] idx);
`ifdef NYAN_TRANSPARENCY_EN
    if (idx == 4'h0) return BG;
`else
`endif
    return pal[idx];
  endfunction

  function automatic bit ref_in_box(input int col, input int row, input int sy);
    return col < COLS && row < ROWS && col >= m_sx && col < m_sx + BOX && row >= sy && row < sy + BOX;
  endfunction

  function automatic int ref_addr(input int col, input int row, input int sy);
    return ((row - sy) / SCALE) * 32 + (col - m_sx) / SCALE;
  endfunction

  function automatic logic [8:0] ref_rgb(input int col, input int row, input int sy);
    if (col >= COLS || row >= ROWS) return 9'h000;
    if (ref_in_box(col, row, sy)) return sprite_rgb(ram[ref_addr(col, row, sy)]);
    return BG;
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '0;
    m_sx = 0; m_div = 0; m_addr = '0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  // One raster cycle: drive, predict, clock, compare every output.
  task automatic step(input int col, input int row, input int sy);
    exp_t e;
    int   exp_tick;
    col_c = 10'(col); row_c = 10'(row); sy_c = 10'(sy);
    hs_i  = 1'($urandom); vs_i = 1'($urandom);
    e.rgb = ref_rgb(col, row, sy); e.hs = hs_i; e.vs = vs_i;
    exp_q.push_back(e);
    if (ref_in_box(col, row, sy)) m_addr = 10'(ref_addr(col, row, sy));
    exp_tick = 0;
    if (col == 0 && row == 0) begin
      if (m_div == FDIV - 1) begin
        m_div = 0; m_sx = (m_sx + 1) % COLS; exp_tick = 1;
      end else m_div++;
    end
    @(posedge clk); #1;
    check("mem_addr", mem_addr, m_addr);
    check("frame_tick", frame_tick, exp_tick);
    if (frame_tick) tick_seen++;
    e = exp_q.pop_front();
    last_rgb  = {red, grn, blu};
    last_addr = mem_addr;
    check("rgb", last_rgb, e.rgb);
    check("syncs", {hs_o, vs_o}, {e.hs, e.vs});
  endtask

  task automatic probe(input string name, input int col, input int row, input int sy,
                       input int kind, input int addr);
    logic [8:0] want;
    step(col, row, sy);
    if (kind == K_SPR) check({name, "_addr"}, last_addr, addr);
    step(1023, 1023, sy);
    step(1023, 1023, sy);
    want = (kind == K_BLACK) ? 9'h000 : (kind == K_BG) ? BG : sprite_rgb(ram[addr]);
    check(name, last_rgb, want);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_rgb"}, {red, grn, blu}, 0);
    check({name, "_syncs"}, {hs_o, vs_o}, 0);
    check({name, "_addr"}, mem_addr, 0);
    check({name, "_tick"}, frame_tick, 0);
  endtask

  vec_t vecs[$];
  int   t0, col, row, sy;

  initial begin
    nvec = 0; nerr = 0; tick_seen = 0;
    for (int i = 0; i < 1024; i++) ram[i] = 4'($urandom);
    ram[10'h062] = 4'h3;
    ram[10'h021] = 4'h0;
    ram[10'h000] = 4'h5;

    rst_n = 1'b0; hs_i = 1'b1; vs_i = 1'b1;
    col_c = 10'd1023; row_c = 10'd1023; sy_c = '0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;
    model_reset();

    // Directed pixels with sprite_x = 0 (no frame start yet).
    vecs = '{
      '{5,   7,   0,  'h062, K_SPR},
      '{63,  0,   0,  31,    K_SPR},
      '{64,  0,   0,  0,     K_BG},
      '{63,  63,  0,  1023,  K_SPR},
      '{63,  64,  0,  0,     K_BG},
      '{2,   2,   0,  'h021, K_SPR},
      '{0,   480, 0,  0,     K_BLACK},
      '{100, 480, 0,  0,     K_BLACK},
      '{640, 5,   0,  0,     K_BLACK},
      '{10,  20,  10, 165,   K_SPR},
      '{10,  9,   10, 0,     K_BG},
      '{62,  100, 50, 831,   K_SPR}
    };
    foreach (vecs[i])
      probe($sformatf("vec%0d", i), vecs[i].col, vecs[i].row, vecs[i].sy, vecs[i].kind, vecs[i].addr);

    // Randomized raster traffic biased around the sprite box.
    sy = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) sy = $urandom_range(0, 1023);
      if ($urandom_range(0, 49) == 0) begin
        col = 0; row = 0;
      end else begin
        col = ($urandom_range(0, 1) != 0) ? ((m_sx + $urandom_range(0, BOX + 6) - 3) & 1023)
                                          : $urandom_range(0, 1023);
        row = ($urandom_range(0, 1) != 0) ? ((sy + $urandom_range(0, BOX + 6) - 3) & 1023)
                                          : $urandom_range(0, 1023);
        if (col == 0 && row == 0) col = 1;
      end
      step(col, row, sy);
    end

    // Asynchronous reset in the middle of a line.
    step(200, 30, 0);
    step(201, 30, 0);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    probe("post_reset_sx0", 0, 5, 5, K_SPR, 0);

    // Four frames at FRAME_DIV=2: two ticks, sprite_x ends at 2.
    t0 = tick_seen;
    for (int f = 0; f < 4; f++) begin
      step(0, 0, 5);
      step(300, 300, 5);
      step(301, 300, 5);
    end
    check("ticks_4frames", tick_seen - t0, 2);
    probe("scroll_sx2_in", 2, 5, 5, K_SPR, 0);
    probe("scroll_sx2_left", 1, 5, 5, K_BG, 0);

    // Advance to sprite_x = 639 and check right-edge clipping.
    for (int n = 0; n < 2000 && m_sx != COLS - 1; n++) step(0, 0, 5);
    check("reached_sx639", m_sx, COLS - 1);
    probe("clip_col639", 639, 5, 5, K_SPR, 0);
    probe("clip_col638", 638, 5, 5, K_BG, 0);
    probe("clip_col640", 640, 5, 5, K_BLACK, 0);
    probe("clip_nowrap0", 0, 5, 5, K_BG, 0);
    probe("clip_nowrap10", 10, 5, 5, K_BG, 0);
    t0 = tick_seen;
    step(0, 0, 5);
    step(0, 0, 5);
    check("wrap_tick", tick_seen - t0, 1);
    probe("wrap_col0", 0, 5, 5, K_SPR, 0);
    probe("wrap_col639", 639, 5, 5, K_BG, 0);

    // Vertical clip with the sprite starting at row 470.
    probe("vclip_470", 0, 470, 470, K_SPR, 0);
    probe("vclip_479", 0, 479, 470, K_SPR, 128);
    probe("vclip_479c5", 5, 479, 470, K_SPR, 130);
    probe("vclip_480", 0, 480, 470, K_BLACK, 0);
    probe("vclip_500", 0, 500, 470, K_BLACK, 0);
    step(0, 0, 470);
    for (int r = 0; r <= 53; r++) probe($sformatf("vclip_next_r%0d", r), 1, r, 470, K_BG, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/nyan_sprite_reader.md
NYAN_SPRITE_READER -- requirements
Module: nyan_sprite_reader

Interface
REQ-001 SHALL have parameter ACTIVE_COLS, default 640: visible columns.
REQ-002 SHALL have parameter ACTIVE_ROWS, default 480: visible rows.
REQ-003 SHALL have parameter SCALE_LOG2, default 1: on-screen pixel replication of 2^SCALE_LOG2; legal values are 0-2.
REQ-004 SHALL have parameter FRAME_DIV, default 2: frames per one-column scroll step; legal values are >=1.
REQ-005 SHALL have parameter BG_COLOR, default 9'h008: {R[2:0],G[2:0],B[2:0]} background colour.
REQ-006 SHALL have i_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-007 SHALL have i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have i_hsync and i_vsync, input, 1 bit each: syncs aligned to the counts.
REQ-009 SHALL have i_col_count and i_row_count, input, 10 bits each: current raster position.
REQ-010 SHALL have i_sprite_y, input, 10 bits: sprite top row.
REQ-011 SHALL have o_mem_addr, output, 10 bits: read address to the pixel RAM.
REQ-012 SHALL have i_mem_data, input, 4 bits: palette index, valid one cycle after o_mem_addr.
REQ-013 SHALL have o_hsync and o_vsync, output, 1 bit each: input syncs delayed 3 cycles.
REQ-014 SHALL have o_red, o_grn and o_blu, output, 3 bits each: pixel colour.
REQ-015 SHALL have o_frame_tick, output, 1 bit: one-cycle pulse on each scroll step.

Function
REQ-016 SHALL treat the sprite as 32x32 at RAM address {sy[4:0],sx[4:0]}, where sx=(col-sprite_x)>>SCALE_LOG2 and sy=(row-i_sprite_y)>>SCALE_LOG2, using 11-bit unsigned subtraction.
REQ-017 SHALL flag in_box when 0<=col-sprite_x<32<<SCALE_LOG2 and 0<=row-i_sprite_y<32<<SCALE_LOG2, with both counts inside the active area.
REQ-018 SHALL run a 3-stage pipeline: stage 1 registers o_mem_addr and in_box; stage 2 captures i_mem_data; stage 3 registers the RGB outputs.
REQ-019 SHALL set input-to-RGB latency to exactly 3 cycles, with o_hsync/o_vsync delayed by the same amount.
REQ-020 SHALL output RGB=0 outside the active area.
REQ-021 SHALL output BG_COLOR inside the active area when not in_box.
REQ-022 SHALL output palette[index] when in_box.
REQ-023 SHALL hold o_mem_addr at its last value when not in_box; the RAM read result is then ignored.
REQ-024 SHALL detect frame start as the cycle with i_col_count==0 and i_row_count==0.
REQ-025 SHALL keep a frame divider 0..FRAME_DIV-1 and, at frame start with divider==FRAME_DIV-1, SHALL clear the divider, increment sprite_x and pulse o_frame_tick on the following cycle.
REQ-026 SHALL wrap sprite_x from ACTIVE_COLS-1 to 0, clipping the sprite at the right edge with no horizontal pixel wrap.
REQ-027 SHALL not render pixels where i_sprite_y+height exceeds ACTIVE_ROWS; there is no vertical wrap.
REQ-028 SHALL apply i_sprite_y combinationally each cycle; changing it mid-frame affects only subsequent pixels.

Reset
REQ-029 SHALL force on reset: sprite_x=0, divider=0, o_mem_addr=0, all pipeline valid/sync registers=0, RGB=0, o_frame_tick=0.
REQ-030 SHALL restart cleanly when reset asserts mid-frame: the first frame start after release produces no o_frame_tick unless FRAME_DIV==1.

Configuration
REQ-031 SHALL, when NYAN_TRANSPARENCY_EN is defined, render index 4'h0 inside the box as BG_COLOR (transparent).
REQ-032 SHALL, when NYAN_TRANSPARENCY_EN is undefined, render index 4'h0 as palette[0] like any other index.

Structure
REQ-033 SHALL place SPRITE_W=32, SPRITE_H=32, SPRITE_ADDR_W=10, SPRITE_DATA_W=4 and the 16-entry 9-bit palette constant in shared package nyan_pkg.
REQ-034 SHALL implement the registered index-to-RGB lookup (stage 3) as sub-module nyan_palette.

Verification
REQ-035 SHALL cover reset: assert i_rst_n=0 mid-line -> all outputs 0, sprite_x=0; release -> first RGB appears 3 cycles after the first active count.
REQ-036 SHALL cover addressing: sprite_x=0, i_sprite_y=0, SCALE_LOG2=1, count (col 5,row 7) -> o_mem_addr=10'h062 one cycle later; model RAM index 4'h3 -> RGB=palette[3] two cycles later.
REQ-037 SHALL cover the box edge: col 63 -> sprite pixel; col 64 -> BG_COLOR; row 480 -> RGB=0, syncs still delayed exactly 3.
REQ-038 SHALL cover scrolling: FRAME_DIV=2, 4 frames -> o_frame_tick pulses twice, sprite_x=2; preset sprite_x=639, one step -> sprite_x=0, right-edge clip verified at col 639.
REQ-039 SHALL cover transparency: index 0 in box -> BG_COLOR with NYAN_TRANSPARENCY_EN, palette[0] without.
REQ-040 SHALL cover the vertical clip: i_sprite_y=470 -> rows 470-479 drawn, no sprite pixels at rows 0-53 of the next frame.
